// File: rtl/led_frame_scheduler_pkg.sv
// Shared types for the LED frame scheduler: matrix type, FSM encoding, counter width
// and the checkerboard helper used by the LED_SCHED_TESTPAT_EN build option.
package led_pkg;

  typedef logic [15:0][15:0] matrix_t;

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    ARB     = 3'd1,
    LAUNCH  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } sched_state_t;

  localparam int unsigned FRAME_CNT_W = 16;

  // Bit [r][c] = r ^ c ^ phase (LSBs only).
  function automatic matrix_t checker_pattern(input logic phase);
    matrix_t m;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        m[r][c] = r[0] ^ c[0] ^ phase;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Handshake between the scheduler (master) and the WS2812 matrix driver (slave).
interface led_frame_scheduler_if import led_pkg::*; ();
  logic    drv_update;
  logic    drv_busy;
  matrix_t drv_matrix;

  modport master (output drv_update, output drv_matrix, input drv_busy);
  modport slave  (input drv_update, input drv_matrix, output drv_busy);
endinterface

// File: rtl/led_frame_scheduler_tick_gen.sv
// Free-running frame slot timer; one-cycle tick on the wrap from FRAME_PERIOD-1 to 0.
module frame_tick_gen #(
  parameter int unsigned CLK_FREQ   = 20_000_000,
  parameter int unsigned FRAME_RATE = 30
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned RawPeriod = CLK_FREQ / FRAME_RATE;
  localparam int unsigned Period    = (RawPeriod < 2) ? 2 : RawPeriod;
  localparam int unsigned CntW      = $clog2(Period);

  logic [CntW-1:0] count_q, count_d;

  assign tick_o = (count_q == CntW'(Period - 1));

  // Next count: wrap at the end of the period.
  always_comb begin
    count_d = tick_o ? '0 : count_q + CntW'(1);
  end

  // Timer register, restarts on reset.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame-rate scheduler sharing one WS2812 driver between two matrix sources.
// Round-robin grant per slot, snapshot of the winner, busy supervision and stats.
// Build option: define LED_SCHED_TESTPAT_EN to load a toggling checkerboard on
// slots with no grant instead of resending the held frame.
module led_frame_scheduler import led_pkg::*; #(
  parameter int unsigned CLK_FREQ     = 20_000_000,
  parameter int unsigned FRAME_RATE   = 30,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             src_valid,
  input  matrix_t                src0_matrix,
  input  matrix_t                src1_matrix,
  output logic [1:0]             src_ack,
  led_frame_scheduler_if.master  drv,
  output logic [1:0]             active_src,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overrun,
  output logic                   drv_error
);

  localparam logic [2:0] StWait   = WAIT;
  localparam logic [2:0] StArb    = ARB;
  localparam logic [2:0] StLaunch = LAUNCH;
  localparam logic [2:0] StWaitHi = WAIT_HI;
  localparam logic [2:0] StWaitLo = WAIT_LO;
  localparam int unsigned ToW     = $clog2(BUSY_TIMEOUT + 1);

  logic [2:0]             state_q, state_d;
  logic                   pending_q, pending_d;
  logic [1:0]             rr_q, rr_d;
  logic [1:0]             active_q, active_d;
  matrix_t                snap_q, snap_d;
  logic [FRAME_CNT_W-1:0] fc_q, fc_d;
  logic                   overrun_q, overrun_d;
  logic                   err_q, err_d;
  logic [ToW-1:0]         to_q, to_d;
  logic                   tick;
  logic [1:0]             other;
  logic [1:0]             grant;
`ifdef LED_SCHED_TESTPAT_EN
  logic                   phase_q, phase_d;
`endif

  frame_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .FRAME_RATE(FRAME_RATE)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick_o(tick)
  );

  // rr_q is one-hot, so its complement is the other source.
  assign other = ~rr_q;

  // Round-robin grant: the non-pointer source first, then the pointer source.
  always_comb begin
    grant = 2'b00;
    if ((src_valid & other) != 2'b00)     grant = other;
    else if ((src_valid & rr_q) != 2'b00) grant = rr_q;
  end

  // Next-state logic for the slot sequencer and statistics.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    active_d  = active_q;
    snap_d    = snap_q;
    fc_d      = fc_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    to_d      = to_q;
`ifdef LED_SCHED_TESTPAT_EN
    phase_d   = phase_q;
`endif

    // A wrap always re-arms pending, even in the cycle WAIT consumes it.
    if (state_q == StWait && pending_q) pending_d = 1'b0;
    if (tick) begin
      pending_d = 1'b1;
      if (state_q != StWait) overrun_d = 1'b1;
    end

    case (state_q)
      StWait: begin
        if (pending_q) state_d = StArb;
      end
      StArb: begin
        active_d = grant;
        if (grant != 2'b00) begin
          rr_d   = grant;
          snap_d = grant[0] ? src0_matrix : src1_matrix;
        end else begin
`ifdef LED_SCHED_TESTPAT_EN
          snap_d  = checker_pattern(phase_q);
          phase_d = ~phase_q;
`endif
        end
        state_d = StLaunch;
      end
      StLaunch: begin
        fc_d    = fc_q + FRAME_CNT_W'(1);
        to_d    = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (drv.drv_busy) begin
          state_d = StWaitLo;
        end else if (to_q == ToW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StWait;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StWaitLo: begin
        if (!drv.drv_busy) state_d = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  // State registers; pointer starts at src1 so src0 wins the first slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StWait;
      pending_q <= 1'b1;
      rr_q      <= 2'b10;
      active_q  <= 2'b00;
      snap_q    <= '0;
      fc_q      <= '0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= '0;
`ifdef LED_SCHED_TESTPAT_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      active_q  <= active_d;
      snap_q    <= snap_d;
      fc_q      <= fc_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      to_q      <= to_d;
`ifdef LED_SCHED_TESTPAT_EN
      phase_q   <= phase_d;
`endif
    end
  end

  assign drv.drv_update = (state_q == StLaunch);
  assign drv.drv_matrix = snap_q;
  assign src_ack        = drv.drv_update ? active_q : 2'b00;
  assign active_src     = active_q;
  assign frame_count    = fc_q;
  assign overrun        = overrun_q;
  assign drv_error      = err_q;

endmodule
